// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, FSM states and
// the contact-code to digit-label map.
package keypad_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_ENTER = 4'd10;
  localparam logic [CODE_W-1:0] KEY_BKSP  = 4'd11;
  localparam logic [CODE_W-1:0] KEY_CLR   = 4'd12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Contact code (row*4+col) to the digit printed on that key
  localparam logic [3:0] DIGIT_MAP [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                            4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

  function automatic logic is_digit(input logic [CODE_W-1:0] code);
    return code < 4'd10;
  endfunction

  function automatic logic [3:0] code_to_digit(input logic [CODE_W-1:0] code);
    return is_digit(code) ? DIGIT_MAP[code] : 4'd0;
  endfunction

endpackage

// File: rtl/keypad_entry_scan.sv
// Row scanner: drives one keypad row low per slot, samples synchronized
// columns at slot end and reports one result per full four-row scan.
module keypad_entry_scan
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_col,
  output logic [3:0]        key_row,
  output logic              scan_done,
  output logic              scan_hit,
  output logic [CODE_W-1:0] scan_code
);

  logic [3:0]        r_col_s1;
  logic [3:0]        r_col_s2;
  logic [15:0]       r_div;
  logic [1:0]        r_row;
  logic [3:0]        r_key_row;
  logic [1:0]        r_hits;
  logic [CODE_W-1:0] r_code;
  logic              r_scan_done;
  logic              r_scan_hit;
  logic [CODE_W-1:0] r_scan_code;

  logic [3:0]        w_closed;
  logic [2:0]        w_slot_n;
  logic [1:0]        w_col_idx;
  logic [2:0]        w_sum;
  logic [1:0]        w_hits_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic              w_slot_end;

  assign w_closed   = ~r_col_s2;
  assign w_slot_n   = 3'(w_closed[0]) + 3'(w_closed[1]) + 3'(w_closed[2]) + 3'(w_closed[3]);
  assign w_slot_end = (r_div == SCAN_DIV - 16'd1);

  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_closed[i]) w_col_idx = 2'(i);
    end
  end

  // Contacts seen so far in this scan, saturating at 2 (multi-press)
  assign w_sum      = 3'(r_row == 2'd0 ? 2'd0 : r_hits) + w_slot_n;
  assign w_hits_nxt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_code_nxt = (w_slot_n != 3'd0) ? {r_row, w_col_idx} : r_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1    <= 4'hF;
      r_col_s2    <= 4'hF;
      r_div       <= 16'd0;
      r_row       <= 2'd0;
      r_key_row   <= 4'b1110;
      r_hits      <= 2'd0;
      r_code      <= '0;
      r_scan_done <= 1'b0;
      r_scan_hit  <= 1'b0;
      r_scan_code <= '0;
    end else begin
      r_col_s1    <= key_col;
      r_col_s2    <= r_col_s1;
      r_scan_done <= 1'b0;
      if (w_slot_end) begin
        r_div     <= 16'd0;
        r_row     <= r_row + 2'd1;
        r_key_row <= {r_key_row[2:0], r_key_row[3]};
        r_hits    <= w_hits_nxt;
        r_code    <= w_code_nxt;
        if (r_row == 2'd3) begin
          r_scan_done <= 1'b1;
          r_scan_hit  <= (w_hits_nxt == 2'd1);
          r_scan_code <= w_code_nxt;
        end
      end else begin
        r_div <= r_div + 16'd1;
      end
    end
  end

  assign key_row   = r_key_row;
  assign scan_done = r_scan_done;
  assign scan_hit  = r_scan_hit;
  assign scan_code = r_scan_code;

endmodule

// File: rtl/keypad_entry.sv
// Keypad numeric entry: debounces scan results into key presses and
// accumulates decimal digits into an edit value committed by ENTER.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4,
  parameter int unsigned VALUE_W        = 21,
  parameter int unsigned MAX_VALUE      = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         key_col,
  output logic [3:0]         key_row,
  output logic [VALUE_W-1:0] edit_value,
  output logic [VALUE_W-1:0] data_out,
  output logic               data_valid,
  output logic [3:0]         key_code,
  output logic               key_strobe
);

  localparam int unsigned PROD_W = VALUE_W + 4;

  logic              w_scan_done;
  logic              w_scan_hit;
  logic [CODE_W-1:0] w_scan_code;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] w_cand_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [3:0]        w_cnt_inc;
  logic              w_strobe_nxt;

  logic [CODE_W-1:0]  r_key_code;
  logic               r_key_strobe;
  logic [VALUE_W-1:0] r_edit;
  logic [VALUE_W-1:0] r_data;
  logic               r_data_valid;
  logic [PROD_W-1:0]  w_prod;

  keypad_entry_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .key_col   (key_col),
    .key_row   (key_row),
    .scan_done (w_scan_done),
    .scan_hit  (w_scan_hit),
    .scan_code (w_scan_code)
  );

  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cand       <= '0;
      r_cnt        <= 4'd0;
      r_key_code   <= '0;
      r_key_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cand       <= w_cand_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_strobe <= w_strobe_nxt;
      if (w_strobe_nxt) r_key_code <= w_cand_nxt;
    end
  end

  // Debounce FSM: advances only on full-scan results
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_scan_hit) begin
            w_cand_nxt = w_scan_code;
            if (DEBOUNCE_SCANS <= 4'd1) begin
              w_state_nxt  = PRESSED;
              w_cnt_nxt    = 4'd0;
              w_strobe_nxt = 1'b1;
            end else begin
              w_state_nxt = DEBOUNCE;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (w_scan_hit && w_scan_code == r_cand) begin
            if (w_cnt_inc >= DEBOUNCE_SCANS) begin
              w_state_nxt  = PRESSED;
              w_cnt_nxt    = 4'd0;
              w_strobe_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        PRESSED: begin
          if (!w_scan_hit) begin
            if (DEBOUNCE_SCANS <= 4'd1) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_state_nxt = RELEASE;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (w_scan_hit) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = 4'd0;
          end else if (w_cnt_inc >= DEBOUNCE_SCANS) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Wide product so an over-range digit is detected rather than wrapped
  assign w_prod = PROD_W'(r_edit) * PROD_W'(10) + PROD_W'(code_to_digit(r_key_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edit       <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (r_key_strobe) begin
        if (is_digit(r_key_code)) begin
          if (w_prod <= PROD_W'(MAX_VALUE)) r_edit <= VALUE_W'(w_prod);
        end else if (r_key_code == KEY_ENTER) begin
          r_data       <= r_edit;
          r_data_valid <= 1'b1;
        end else if (r_key_code == KEY_BKSP) begin
          r_edit <= r_edit / VALUE_W'(10);
        end else if (r_key_code == KEY_CLR) begin
          r_edit <= '0;
        end
      end
    end
  end

  assign edit_value = r_edit;
  assign data_out   = r_data;
  assign data_valid = r_data_valid;
  assign key_code   = r_key_code;
  assign key_strobe = r_key_strobe;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: behavioural matrix keypad driven from a set of
// pressed contacts, with an arithmetic model of the expected entry value.
module tb_keypad_entry;

  localparam int SCAN_CYC = 16;
  localparam int MAXV     = 2000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [20:0] edit_value;
  logic [20:0] data_out;
  logic        data_valid;
  logic [3:0]  key_code;
  logic        key_strobe;

  logic [15:0] pressed = '0;

  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_valid = 0;
  int last_code = -1;
  longint m_edit = 0;
  longint m_data = 0;
  int exp_strobe = 0;
  int exp_valid = 0;

  keypad_entry #(
    .SCAN_DIV(16'd4), .DEBOUNCE_SCANS(4'd2), .VALUE_W(21), .MAX_VALUE(2000000)
  ) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .edit_value(edit_value), .data_out(data_out), .data_valid(data_valid),
    .key_code(key_code), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed contact pulls its column low while its row is driven low
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_strobe) begin
      n_strobe++;
      last_code = int'(key_code);
    end
    if (data_valid) n_valid++;
  end

  task automatic model_key(input int code);
    if (code < 10) begin
      if (m_edit * 10 + code <= MAXV) m_edit = m_edit * 10 + code;
    end else if (code == 10) begin
      m_data = m_edit;
      exp_valid++;
    end else if (code == 11) begin
      m_edit = m_edit / 10;
    end else if (code == 12) begin
      m_edit = 0;
    end
  endtask

  task automatic press_key(input int code, input int hold_scans);
    pressed = 16'd1 << code;
    repeat (hold_scans * SCAN_CYC) @(negedge clk);
    pressed = '0;
    repeat (3 * SCAN_CYC) @(negedge clk);
    model_key(code);
    exp_strobe++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (key_row !== 4'b1110 || edit_value !== 21'd0 || data_out !== 21'd0 ||
        key_code !== 4'd0 || data_valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: row=%b edit=%0d data=%0d code=%0d dv=%b ks=%b",
               key_row, edit_value, data_out, key_code, data_valid, key_strobe);
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (key_row !== exp_row) begin
        failures++;
        $display("FAIL row_seq[%0d]: got %b want %b", k, key_row, exp_row);
      end
    end
  endtask

  task automatic test_entry();
    int codes [4] = '{1, 2, 3, 10};
    int exp_e [4] = '{1, 12, 123, 123};
    for (int i = 0; i < 4; i++) begin
      press_key(codes[i], 3);
      checks++;
      if (n_strobe !== exp_strobe || last_code !== codes[i] || edit_value !== 21'(exp_e[i])) begin
        failures++;
        $display("FAIL entry[%0d]: strobes=%0d/%0d code=%0d/%0d edit=%0d/%0d",
                 i, n_strobe, exp_strobe, last_code, codes[i], edit_value, exp_e[i]);
      end
    end
    checks++;
    if (data_out !== 21'd123 || n_valid !== 1 || exp_valid !== 1) begin
      failures++;
      $display("FAIL enter_commit: data=%0d want 123 valid_pulses=%0d want 1", data_out, n_valid);
    end
  endtask

  task automatic test_glitch();
    pressed = 16'd1 << 5;
    repeat (12) @(negedge clk);
    pressed = '0;
    repeat (4 * SCAN_CYC) @(negedge clk);
    checks++;
    if (n_strobe !== exp_strobe || edit_value !== 21'(m_edit)) begin
      failures++;
      $display("FAIL glitch: strobes=%0d want %0d edit=%0d want %0d",
               n_strobe, exp_strobe, edit_value, m_edit);
    end
  endtask

  task automatic test_max();
    int seq [8] = '{12, 2, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) press_key(seq[i], 3);
    checks++;
    if (edit_value !== 21'd200000 || m_edit != 200000) begin
      failures++;
      $display("FAIL max_over: edit=%0d want 200000", edit_value);
    end
    press_key(0, 3);
    checks++;
    if (edit_value !== 21'd2000000 || n_strobe !== exp_strobe) begin
      failures++;
      $display("FAIL max_exact: edit=%0d want 2000000 strobes=%0d/%0d",
               edit_value, n_strobe, exp_strobe);
    end
  endtask

  task automatic test_multi();
    pressed = (16'd1 << 1) | (16'd1 << 2);
    repeat (4 * SCAN_CYC) @(negedge clk);
    pressed = '0;
    repeat (3 * SCAN_CYC) @(negedge clk);
    checks++;
    if (n_strobe !== exp_strobe || edit_value !== 21'(m_edit)) begin
      failures++;
      $display("FAIL multi_press: strobes=%0d want %0d edit=%0d", n_strobe, exp_strobe, edit_value);
    end
    // Release bounce on an ignored key: NONE, KEY, NONE, NONE
    pressed = 16'd1 << 13;
    repeat (3 * SCAN_CYC) @(negedge clk);
    pressed = '0;
    repeat (SCAN_CYC) @(negedge clk);
    pressed = 16'd1 << 13;
    repeat (SCAN_CYC) @(negedge clk);
    pressed = '0;
    repeat (3 * SCAN_CYC) @(negedge clk);
    exp_strobe++;
    checks++;
    if (n_strobe !== exp_strobe || last_code !== 13 || edit_value !== 21'(m_edit)) begin
      failures++;
      $display("FAIL release_bounce: strobes=%0d want %0d code=%0d want 13 edit=%0d",
               n_strobe, exp_strobe, last_code, edit_value);
    end
  endtask

  task automatic test_edit();
    int seq [5] = '{12, 4, 5, 11, 12};
    int exp_e [5] = '{0, 4, 45, 4, 0};
    for (int i = 0; i < 5; i++) begin
      press_key(seq[i], 3);
      checks++;
      if (edit_value !== 21'(exp_e[i]) || data_out !== 21'd123) begin
        failures++;
        $display("FAIL edit[%0d]: edit=%0d want %0d data=%0d want 123",
                 i, edit_value, exp_e[i], data_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int code;
      code = int'($urandom_range(0, 13));
      press_key(code, 3);
      checks++;
      if (n_strobe !== exp_strobe || last_code !== code || edit_value !== 21'(m_edit) ||
          data_out !== 21'(m_data) || n_valid !== exp_valid) begin
        failures++;
        $display("FAIL random[%0d] key %0d: strobes=%0d/%0d code=%0d edit=%0d/%0d data=%0d/%0d dv=%0d/%0d",
                 i, code, n_strobe, exp_strobe, last_code, edit_value, m_edit,
                 data_out, m_data, n_valid, exp_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    press_key(9, 3);
    press_key(10, 3);
    pressed = 16'd1 << 3;
    repeat (SCAN_CYC + 6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_edit = 0;
    m_data = 0;
    checks++;
    if (key_row !== 4'b1110 || edit_value !== 21'd0 || data_out !== 21'd0 ||
        key_code !== 4'd0 || data_valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: row=%b edit=%0d data=%0d code=%0d dv=%b ks=%b",
               key_row, edit_value, data_out, key_code, data_valid, key_strobe);
    end
    pressed = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4 * SCAN_CYC) @(negedge clk);
    checks++;
    if (n_strobe !== exp_strobe || n_valid !== exp_valid || edit_value !== 21'd0 || data_out !== 21'd0) begin
      failures++;
      $display("FAIL after_reset: strobes=%0d/%0d dv=%0d/%0d edit=%0d data=%0d",
               n_strobe, exp_strobe, n_valid, exp_valid, edit_value, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_glitch();
    test_max();
    test_multi();
    test_edit();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
